// File: rtl/adpll_pkg.sv
// ---------------------------------------------------------------------------
// adpll_pkg
//   Shared definitions for the ADPLL loop-control blocks: the gear encoding
//   seen on gear_o, the scheduler state type built on it, the window
//   comparison mode for error_window_counter, and a saturating two's-
//   complement magnitude helper reused by lock detectors and benches.
// ---------------------------------------------------------------------------
package adpll_pkg;

    localparam logic [1:0] GEAR_IDLE = 2'd0;
    localparam logic [1:0] GEAR_ACQ  = 2'd1;
    localparam logic [1:0] GEAR_TRK  = 2'd2;
    localparam logic [1:0] GEAR_LCK  = 2'd3;

    // State values equal the gear code so gear_o is the state register itself.
    typedef enum logic [1:0] {
        ST_IDLE = GEAR_IDLE,
        ST_ACQ  = GEAR_ACQ,
        ST_TRK  = GEAR_TRK,
        ST_LCK  = GEAR_LCK
    } gear_state_e;

    // WIN_INSIDE: hit when |e| <= threshold; WIN_OUTSIDE: hit when |e| > threshold.
    typedef enum logic {
        WIN_INSIDE,
        WIN_OUTSIDE
    } win_mode_e;

    // Magnitude of a sign-extended w-bit value. The most-negative w-bit value
    // has no positive counterpart, so it saturates to 2^(w-1)-1.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] e,
                                            input int unsigned         w);
        logic signed [31:0] most_neg;
        most_neg = -(32'sd1 <<< (w - 1));
        if (e == most_neg) begin
            return (32'd1 << (w - 1)) - 32'd1;
        end else if (e < 0) begin
            return unsigned'(-e);
        end else begin
            return unsigned'(e);
        end
    endfunction

endpackage

// File: rtl/error_window_counter.sv
// ---------------------------------------------------------------------------
// error_window_counter
//   Compares |error_i| against a threshold and counts consecutive samples
//   that fall in the selected window. The count clears on any miss or on
//   clear_i and saturates at SAT_COUNT.
// Ports
//   gen_clk_i  in   1            clock, rising edge
//   reset_i    in   1            asynchronous, active-high reset
//   clear_i    in   1            synchronous clear of the run counter
//   error_i    in   ERROR_WIDTH  signed error sample
//   hit_o      out  1            current sample is in the window (combinational)
//   cnt_o      out  CNT_WIDTH    consecutive hits before this sample (registered)
// ---------------------------------------------------------------------------
module error_window_counter
    import adpll_pkg::*;
#(
    parameter int unsigned ERROR_WIDTH = 5,
    parameter int unsigned THRESH      = 2,
    parameter win_mode_e   MODE        = WIN_INSIDE,
    parameter int unsigned SAT_COUNT   = 16,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                          gen_clk_i,
    input  logic                          reset_i,
    input  logic                          clear_i,
    input  logic signed [ERROR_WIDTH-1:0] error_i,
    output logic                          hit_o,
    output logic [CNT_WIDTH-1:0]          cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(SAT_COUNT);

    logic [31:0]          mag;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q;

    always_comb begin
        mag = abs_sat(32'(error_i), ERROR_WIDTH);
        if (MODE == WIN_INSIDE) begin
            hit_o = (mag <= THRESH);
        end else begin
            hit_o = (mag > THRESH);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !hit_o) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/loop_gain_scheduler.sv
// ---------------------------------------------------------------------------
// loop_gain_scheduler
//   Gear-shifting kp/ki controller for the ADPLL PI loop filter. Steps
//   IDLE -> ACQUIRE -> TRACK -> LOCKED as the phase error settles and drops
//   back to ACQUIRE on a run of large errors. Every gear change blanks the
//   error for SETTLE_CYCLES edges so the loop can absorb the new gains.
// Ports
//   gen_clk_i      in   1            generated clock, rising edge
//   reset_i        in   1            asynchronous, active-high reset
//   enable_i       in   1            1 = run scheduler; 0 = force IDLE
//   error_i        in   ERROR_WIDTH  signed phase error, sampled every edge
//   kp_o           out  KP_WIDTH     proportional gain, registered
//   ki_o           out  KI_WIDTH     integral gain, registered
//   gear_o         out  2            0 IDLE, 1 ACQUIRE, 2 TRACK, 3 LOCKED
//   locked_o       out  1            1 while in LOCKED
//   gain_update_o  out  1            one-cycle pulse on every gear change
// ---------------------------------------------------------------------------
module loop_gain_scheduler
    import adpll_pkg::*;
#(
    parameter int unsigned ERROR_WIDTH   = 5,
    parameter int unsigned KP_WIDTH      = 5,
    parameter int unsigned KI_WIDTH      = 7,
    parameter int unsigned KP_ACQ        = 8,
    parameter int unsigned KI_ACQ        = 16,
    parameter int unsigned KP_TRK        = 4,
    parameter int unsigned KI_TRK        = 4,
    parameter int unsigned KP_LCK        = 1,
    parameter int unsigned KI_LCK        = 1,
    parameter int unsigned LOCK_THRESH   = 2,
    parameter int unsigned UNLOCK_THRESH = 6,
    parameter int unsigned LOCK_COUNT    = 16,
    parameter int unsigned UNLOCK_COUNT  = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                          gen_clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic signed [ERROR_WIDTH-1:0] error_i,
    output logic [KP_WIDTH-1:0]           kp_o,
    output logic [KI_WIDTH-1:0]           ki_o,
    output logic [1:0]                    gear_o,
    output logic                          locked_o,
    output logic                          gain_update_o
);

    localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] UNLOCK_LAST = CNT_WIDTH'(UNLOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES);

    gear_state_e          state_q;
    gear_state_e          state_d;
    logic [CNT_WIDTH-1:0] settle_q;
    logic [CNT_WIDTH-1:0] settle_d;
    logic [KP_WIDTH-1:0]  kp_q;
    logic [KP_WIDTH-1:0]  kp_d;
    logic [KI_WIDTH-1:0]  ki_q;
    logic [KI_WIDTH-1:0]  ki_d;
    logic                 gain_update_q;
    logic                 gain_update_d;

    logic                 in_win;
    logic                 out_win;
    logic [CNT_WIDTH-1:0] good_cnt;
    logic [CNT_WIDTH-1:0] bad_cnt;
    logic                 settled;
    logic                 state_change;
    logic                 cnt_clear;

    error_window_counter #(
        .ERROR_WIDTH (ERROR_WIDTH),
        .THRESH      (LOCK_THRESH),
        .MODE        (WIN_INSIDE),
        .SAT_COUNT   (LOCK_COUNT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_lock_win (
        .gen_clk_i (gen_clk_i),
        .reset_i   (reset_i),
        .clear_i   (cnt_clear),
        .error_i   (error_i),
        .hit_o     (in_win),
        .cnt_o     (good_cnt)
    );

    error_window_counter #(
        .ERROR_WIDTH (ERROR_WIDTH),
        .THRESH      (UNLOCK_THRESH),
        .MODE        (WIN_OUTSIDE),
        .SAT_COUNT   (UNLOCK_COUNT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_unlock_win (
        .gen_clk_i (gen_clk_i),
        .reset_i   (reset_i),
        .clear_i   (cnt_clear),
        .error_i   (error_i),
        .hit_o     (out_win),
        .cnt_o     (bad_cnt)
    );

    // Next state. The shift decision uses the stored run (cnt == N-1) plus the
    // live sample, so the gear changes on the edge that samples the N-th hit.
    always_comb begin
        state_d = state_q;
        settled = (settle_q == '0);
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else if (settled) begin
            case (state_q)
                ST_IDLE: state_d = ST_ACQ;
                ST_ACQ: begin
                    if (good_cnt == LOCK_LAST && in_win) begin
                        state_d = ST_TRK;
                    end
                end
                ST_TRK: begin
                    if (good_cnt == LOCK_LAST && in_win) begin
                        state_d = ST_LCK;
                    end else if (bad_cnt == UNLOCK_LAST && out_win) begin
                        state_d = ST_ACQ;
                    end
                end
                ST_LCK: begin
                    if (bad_cnt == UNLOCK_LAST && out_win) begin
                        state_d = ST_ACQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Settle blanking, counter clear and the registered gain set, all keyed
    // off the state being entered so outputs move on the deciding edge.
    always_comb begin
        state_change = (state_d != state_q);
        settle_d     = settle_q;
        if (state_change) begin
            settle_d = SETTLE_LOAD;
        end else if (!settled) begin
            settle_d = settle_q - CNT_WIDTH'(1);
        end
        cnt_clear     = state_change || !settled;
        gain_update_d = state_change;

        kp_d = KP_WIDTH'(KP_ACQ);
        ki_d = KI_WIDTH'(KI_ACQ);
        case (state_d)
            ST_TRK: begin
                kp_d = KP_WIDTH'(KP_TRK);
                ki_d = KI_WIDTH'(KI_TRK);
            end
            ST_LCK: begin
                kp_d = KP_WIDTH'(KP_LCK);
                ki_d = KI_WIDTH'(KI_LCK);
            end
            default: begin
                kp_d = KP_WIDTH'(KP_ACQ);
                ki_d = KI_WIDTH'(KI_ACQ);
            end
        endcase
    end

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            settle_q      <= '0;
            kp_q          <= KP_WIDTH'(KP_ACQ);
            ki_q          <= KI_WIDTH'(KI_ACQ);
            gain_update_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            kp_q          <= kp_d;
            ki_q          <= ki_d;
            gain_update_q <= gain_update_d;
        end
    end

    assign kp_o          = kp_q;
    assign ki_o          = ki_q;
    assign gear_o        = state_q;
    assign locked_o      = (state_q == ST_LCK);
    assign gain_update_o = gain_update_q;

endmodule

// File: tb/tb_loop_gain_scheduler.sv
module tb_loop_gain_scheduler;

    localparam int EW       = 5;
    localparam int EMAX     = 15;
    localparam int LOCK_T   = 2;
    localparam int UNLOCK_T = 6;
    localparam int LOCK_N   = 16;
    localparam int UNLOCK_N = 4;
    localparam int SETTLE   = 8;

    logic                 gen_clk_i = 1'b0;
    logic                 reset_i;
    logic                 enable_i;
    logic signed [EW-1:0] error_i;
    logic [4:0]           kp_o;
    logic [6:0]           ki_o;
    logic [1:0]           gear_o;
    logic                 locked_o;
    logic                 gain_update_o;

    int total = 0;
    int bad   = 0;

    loop_gain_scheduler #(
        .ERROR_WIDTH   (5),
        .KP_WIDTH      (5),
        .KI_WIDTH      (7),
        .KP_ACQ        (8),
        .KI_ACQ        (16),
        .KP_TRK        (4),
        .KI_TRK        (4),
        .KP_LCK        (1),
        .KI_LCK        (1),
        .LOCK_THRESH   (2),
        .UNLOCK_THRESH (6),
        .LOCK_COUNT    (16),
        .UNLOCK_COUNT  (4),
        .SETTLE_CYCLES (8),
        .CNT_WIDTH     (8)
    ) dut (
        .gen_clk_i     (gen_clk_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .error_i       (error_i),
        .kp_o          (kp_o),
        .ki_o          (ki_o),
        .gear_o        (gear_o),
        .locked_o      (locked_o),
        .gain_update_o (gain_update_o)
    );

    always #5 gen_clk_i = ~gen_clk_i;

    // Reference model: the gear moves when the trailing run of post-settle
    // samples since the last gear change is long enough.
    int m_gear;
    int m_since;
    int m_upd;
    int m_hist[$];

    function automatic int kp_of(input int g);
        return (g <= 1) ? 8 : (g == 2) ? 4 : 1;
    endfunction

    function automatic int ki_of(input int g);
        return (g <= 1) ? 16 : (g == 2) ? 4 : 1;
    endfunction

    function automatic void model_reset();
        m_gear  = 0;
        m_since = SETTLE;
        m_upd   = 0;
        m_hist.delete();
    endfunction

    function automatic void model_step(input bit en, input int e);
        int a;
        int in_run;
        int out_run;
        int nxt;
        a = (e < 0) ? -e : e;
        if (a > EMAX) a = EMAX;
        if (m_since < 100000) m_since++;
        nxt = m_gear;
        if (!en) begin
            nxt = 0;
        end else if (m_since > SETTLE) begin
            m_hist.push_back(a);
            if (m_hist.size() > 64) void'(m_hist.pop_front());
            in_run = 0;
            for (int i = m_hist.size() - 1; i >= 0 && m_hist[i] <= LOCK_T; i--) in_run++;
            out_run = 0;
            for (int i = m_hist.size() - 1; i >= 0 && m_hist[i] > UNLOCK_T; i--) out_run++;
            case (m_gear)
                0: nxt = 1;
                1: if (in_run >= LOCK_N) nxt = 2;
                2: if (in_run >= LOCK_N) nxt = 3;
                   else if (out_run >= UNLOCK_N) nxt = 1;
                default: if (out_run >= UNLOCK_N) nxt = 1;
            endcase
        end
        m_upd = (nxt != m_gear) ? 1 : 0;
        if (nxt != m_gear) begin
            m_gear  = nxt;
            m_since = 0;
            m_hist.delete();
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input int g, input int kp, input int ki,
                           input int lck, input int upd);
        chk({name, ".gear"},   int'(gear_o),        g);
        chk({name, ".kp"},     int'(kp_o),          kp);
        chk({name, ".ki"},     int'(ki_o),          ki);
        chk({name, ".locked"}, int'(locked_o),      lck);
        chk({name, ".upd"},    int'(gain_update_o), upd);
    endtask

    task automatic chk_model(input string name);
        chk_all(name, m_gear, kp_of(m_gear), ki_of(m_gear), (m_gear == 3) ? 1 : 0, m_upd);
    endtask

    // Drive inputs, take one rising edge, advance the model, sample 1 ns later.
    task automatic apply(input bit en, input int e);
        enable_i = en;
        error_i  = EW'(e);
        @(posedge gen_clk_i);
        model_step(en, e);
        #1;
    endtask

    task automatic cycle(input bit en, input int e);
        apply(en, e);
        chk_model("model");
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        #1;
        @(posedge gen_clk_i);
        #1;
        reset_i = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit en;
        int err;
        int gear;
        int kp;
        int ki;
        int lck;
        int upd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int phase;
        int left;
        int e;
        int r;
        bit en;

        vecs[0] = '{1'b1,  1, 1, 8, 16, 0, 1};
        vecs[1] = '{1'b1,  1, 1, 8, 16, 0, 0};
        vecs[2] = '{1'b1,  5, 1, 8, 16, 0, 0};
        vecs[3] = '{1'b0,  0, 0, 8, 16, 0, 1};
        vecs[4] = '{1'b0,  0, 0, 8, 16, 0, 0};
        vecs[5] = '{1'b1,  0, 0, 8, 16, 0, 0};

        reset_i  = 1'b1;
        enable_i = 1'b1;
        error_i  = EW'(1);
        model_reset();
        #2;
        chk_all("reset_async", 0, 8, 16, 0, 0);
        @(posedge gen_clk_i);
        #1;
        chk_all("reset_held", 0, 8, 16, 0, 0);
        reset_i = 1'b0;

        // Table: first gear-in after reset, then enable drop and settle in IDLE.
        for (int i = 0; i < 6; i++) begin
            apply(vecs[i].en, vecs[i].err);
            chk_all($sformatf("vec%0d", i), vecs[i].gear, vecs[i].kp, vecs[i].ki,
                    vecs[i].lck, vecs[i].upd);
        end

        // Gear walk with error=+1 held.
        do_reset();
        cycle(1'b1, 1);
        chk_all("t2_acq", 1, 8, 16, 0, 1);
        for (int i = 0; i < 23; i++) cycle(1'b1, 1);
        chk_all("t2_pre_trk", 1, 8, 16, 0, 0);
        cycle(1'b1, 1);
        chk_all("t2_trk", 2, 4, 4, 0, 1);
        for (int i = 0; i < 23; i++) cycle(1'b1, 1);
        chk_all("t2_pre_lck", 2, 4, 4, 0, 0);
        cycle(1'b1, 1);
        chk_all("t2_lck", 3, 1, 1, 1, 1);

        // Unlock bursts in LOCKED.
        for (int i = 0; i < 10; i++) cycle(1'b1, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 7);
        cycle(1'b1, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 7);
        chk_all("t3_hold", 3, 1, 1, 1, 0);
        cycle(1'b1, 7);
        chk_all("t3_drop", 1, 8, 16, 0, 1);

        // Saturating magnitude and a broken in-window run in ACQUIRE.
        for (int i = 0; i < 8; i++) cycle(1'b1, 0);
        for (int i = 0; i < 20; i++) cycle(1'b1, -16);
        chk_all("t4_sat", 1, 8, 16, 0, 0);
        for (int i = 0; i < 15; i++) cycle(1'b1, 0);
        cycle(1'b1, 3);
        for (int i = 0; i < 15; i++) cycle(1'b1, -2);
        chk_all("t4_rerun", 1, 8, 16, 0, 0);
        cycle(1'b1, 2);
        chk_all("t4_trk", 2, 4, 4, 0, 1);

        // Enable drop during TRACK settle, then re-enable.
        cycle(1'b0, 0);
        chk_all("t5_idle", 0, 8, 16, 0, 1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 0);
        cycle(1'b1, 0);
        chk_all("t5_reacq", 1, 8, 16, 0, 1);
        for (int i = 0; i < 23; i++) cycle(1'b1, 0);
        chk_all("t5_settle_hold", 1, 8, 16, 0, 0);
        cycle(1'b1, 0);
        chk_all("t5_trk", 2, 4, 4, 0, 1);

        // Asynchronous reset mid-cycle while LOCKED.
        for (int i = 0; i < 24; i++) cycle(1'b1, 0);
        chk_all("t6_lck", 3, 1, 1, 1, 1);
        #3;
        reset_i = 1'b1;
        #1;
        chk_all("t6_async", 0, 8, 16, 0, 0);
        @(posedge gen_clk_i);
        #1;
        reset_i = 1'b0;
        model_reset();

        // Randomized bursts against the model.
        left  = 0;
        phase = 0;
        for (int n = 0; n < 2500; n++) begin
            if (left == 0) begin
                r     = int'($urandom_range(0, 9));
                phase = (r < 6) ? 0 : (r < 8) ? 1 : 2;
                left  = int'($urandom_range(1, 60));
            end
            left--;
            case (phase)
                0:       e = int'($urandom_range(0, 4)) - 2;
                1:       e = int'($urandom_range(0, 31)) - 16;
                default: e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(7, 15))
                                                         : -int'($urandom_range(7, 16));
            endcase
            en = ($urandom_range(0, 63) != 0);
            cycle(en, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
